pipe_hazard_ctrl: RTL and testbench

Sequencing controller for the 5-stage pipeline registers. It detects load-use hazards, redirects on taken branches and jumps, and freezes the front of the pipe while a multi-cycle multiply/divide occupies EX. It drives the load and flush controls of the IF/ID register, the PC load, and the ID/EX and EX/MEM bubble controls. It also keeps saturating stall and flush performance counters.

---
 rtl/pipe_ctrl_pkg.sv | 25 ++
 rtl/lu_detect.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constant control vectors for the pipeline hazard controller.
package pipe_ctrl_pkg;

   localparam int REG_AW_DEF = 5;
   localparam int CNT_W_DEF  = 32;

   typedef enum logic {RUN, MD_WAIT} state_t;

   typedef struct packed {
      logic pc_ld;
      logic ifid_ld;
      logic idex_ld;
      logic ifid_flush;
      logic idex_bubble;
      logic exmem_bubble;
   } ctrl_t;

   localparam ctrl_t CTRL_NORMAL = '{pc_ld: 1'b1, ifid_ld: 1'b1, idex_ld: 1'b1,
                                     ifid_flush: 1'b0, idex_bubble: 1'b0, exmem_bubble: 1'b0};
   localparam ctrl_t CTRL_FREEZE = '{pc_ld: 1'b0, ifid_ld: 1'b0, idex_ld: 1'b0,
                                     ifid_flush: 1'b0, idex_bubble: 1'b0, exmem_bubble: 1'b1};
   localparam ctrl_t CTRL_RESET  = '{pc_ld: 1'b0, ifid_ld: 1'b0, idex_ld: 1'b0,
                                     ifid_flush: 1'b0, idex_bubble: 1'b1, exmem_bubble: 1'b0};

endpackage

// File: rtl/lu_detect.sv
// Load-use hazard detector: a load in EX writes a register the ID instruction reads.
module lu_detect
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_AW = REG_AW_DEF
) (
   input  logic              idex_memread,
   input  logic [REG_AW-1:0] idex_rt,
   input  logic [REG_AW-1:0] ifid_rs,
   input  logic [REG_AW-1:0] ifid_rt,
   input  logic              ifid_uses_rt,
   output logic              lu
);

   logic w_rs_hit;
   logic w_rt_hit;

   // Register 0 is hard-wired zero, so a load targeting it never creates a hazard.
   assign w_rs_hit = (idex_rt == ifid_rs);
   assign w_rt_hit = ifid_uses_rt && (idex_rt == ifid_rt);
   assign lu       = idex_memread && (idex_rt != '0) && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, redirect flushes, mul/div freeze
// and saturating stall/flush performance counters.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MD_CYCLES = 4,
   parameter int REG_AW    = REG_AW_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] ifid_rs,
   input  logic [REG_AW-1:0] ifid_rt,
   input  logic              ifid_uses_rt,
   input  logic              idex_memread,
   input  logic [REG_AW-1:0] idex_rt,
   input  logic              br_taken,
   input  logic              jump,
   input  logic              md_start,
   input  logic              cnt_clr,
   output logic              pc_ld,
   output logic              ifid_ld,
   output logic              idex_ld,
   output logic              ifid_flush,
   output logic              idex_bubble,
   output logic              exmem_bubble,
   output logic              md_busy,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam int MDW = ($clog2(MD_CYCLES) > 1) ? $clog2(MD_CYCLES) : 1;

   state_t           r_state;
   logic [MDW-1:0]   r_md_cnt;
   logic             r_md_busy;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;
   logic             w_lu;
   logic             w_rd;
   logic             w_freeze;
   ctrl_t            w_ctrl;

   lu_detect #(.REG_AW(REG_AW)) u_lu_detect (
      .idex_memread (idex_memread),
      .idex_rt      (idex_rt),
      .ifid_rs      (ifid_rs),
      .ifid_rt      (ifid_rt),
      .ifid_uses_rt (ifid_uses_rt),
      .lu           (w_lu)
   );

   assign w_rd     = br_taken || jump;
   // The release cycle (MD_WAIT with md_cnt==0) ignores md_start and behaves like RUN.
   assign w_freeze = ((r_state == RUN) && md_start) ||
                     ((r_state == MD_WAIT) && (r_md_cnt != '0));

   always_comb begin
      // NOTE: assign a default first so every path drives w_ctrl and no latch is inferred.
      w_ctrl = CTRL_NORMAL;
      if (!rst) begin
         w_ctrl = CTRL_RESET;
      end else if (w_freeze) begin
         w_ctrl = CTRL_FREEZE;
      end else if (w_lu) begin
         w_ctrl.pc_ld       = 1'b0;
         w_ctrl.ifid_ld     = 1'b0;
         w_ctrl.idex_bubble = 1'b1;
      end else if (w_rd) begin
         w_ctrl.ifid_flush  = 1'b1;
         w_ctrl.pc_ld       = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= RUN;
         r_md_cnt  <= '0;
         r_md_busy <= 1'b0;
      end else begin
         case (r_state)
            RUN: begin
               if (md_start) begin
                  r_state   <= MD_WAIT;
                  r_md_cnt  <= MDW'(MD_CYCLES - 2);
                  r_md_busy <= 1'b1;
               end
            end
            MD_WAIT: begin
               if (r_md_cnt != '0) begin
                  r_md_cnt <= r_md_cnt - 1'b1;
               end else begin
                  r_state   <= RUN;
                  r_md_busy <= 1'b0;
               end
            end
            default: begin
               r_state   <= RUN;
               r_md_busy <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else if (cnt_clr) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (!w_ctrl.pc_ld && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
         if (w_ctrl.ifid_flush && (r_flush_cnt != '1)) begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
         end
      end
   end

   assign pc_ld        = w_ctrl.pc_ld;
   assign ifid_ld      = w_ctrl.ifid_ld;
   assign idex_ld      = w_ctrl.idex_ld;
   assign ifid_flush   = w_ctrl.ifid_flush;
   assign idex_bubble  = w_ctrl.idex_bubble;
   assign exmem_bubble = w_ctrl.exmem_bubble;
   assign md_busy      = r_md_busy;
   assign stall_cnt    = r_stall_cnt;
   assign flush_cnt    = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: dut_a (MD_CYCLES=4, CNT_W=32) and dut_b (MD_CYCLES=2, CNT_W=4) share stimulus.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] ifid_rs, ifid_rt, idex_rt;
   logic       ifid_uses_rt, idex_memread, br_taken, jump, md_start, cnt_clr;

   logic        a_pc_ld, a_ifid_ld, a_idex_ld, a_ifid_flush, a_idex_bubble, a_exmem_bubble, a_md_busy;
   logic [31:0] a_stall_cnt, a_flush_cnt;
   logic        b_pc_ld, b_ifid_ld, b_idex_ld, b_ifid_flush, b_idex_bubble, b_exmem_bubble, b_md_busy;
   logic [3:0]  b_stall_cnt, b_flush_cnt;
   logic [6:0]  a_vec, b_vec;

   int checks = 0;
   int errors = 0;

   // Expected vectors: {pc_ld, ifid_ld, idex_ld, ifid_flush, idex_bubble, exmem_bubble, md_busy}
   localparam logic [6:0] V_RST   = 7'b0000100;
   localparam logic [6:0] V_NORM  = 7'b1110000;
   localparam logic [6:0] V_LU    = 7'b0010100;
   localparam logic [6:0] V_RD    = 7'b1111000;
   localparam logic [6:0] V_FRZ0  = 7'b0000010;
   localparam logic [6:0] V_FRZ1  = 7'b0000011;
   localparam logic [6:0] V_REL   = 7'b1110001;
   localparam logic [6:0] V_RELRD = 7'b1111001;

   always #5 clk = ~clk;

   assign a_vec = {a_pc_ld, a_ifid_ld, a_idex_ld, a_ifid_flush, a_idex_bubble, a_exmem_bubble, a_md_busy};
   assign b_vec = {b_pc_ld, b_ifid_ld, b_idex_ld, b_ifid_flush, b_idex_bubble, b_exmem_bubble, b_md_busy};

   pipe_hazard_ctrl #(.MD_CYCLES(4), .REG_AW(5), .CNT_W(32)) dut_a (
      .clk(clk), .rst(rst), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
      .idex_memread(idex_memread), .idex_rt(idex_rt), .br_taken(br_taken), .jump(jump),
      .md_start(md_start), .cnt_clr(cnt_clr), .pc_ld(a_pc_ld), .ifid_ld(a_ifid_ld),
      .idex_ld(a_idex_ld), .ifid_flush(a_ifid_flush), .idex_bubble(a_idex_bubble),
      .exmem_bubble(a_exmem_bubble), .md_busy(a_md_busy), .stall_cnt(a_stall_cnt),
      .flush_cnt(a_flush_cnt)
   );

   pipe_hazard_ctrl #(.MD_CYCLES(2), .REG_AW(5), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
      .idex_memread(idex_memread), .idex_rt(idex_rt), .br_taken(br_taken), .jump(jump),
      .md_start(md_start), .cnt_clr(cnt_clr), .pc_ld(b_pc_ld), .ifid_ld(b_ifid_ld),
      .idex_ld(b_idex_ld), .ifid_flush(b_ifid_flush), .idex_bubble(b_idex_bubble),
      .exmem_bubble(b_exmem_bubble), .md_busy(b_md_busy), .stall_cnt(b_stall_cnt),
      .flush_cnt(b_flush_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs change here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Combinational outputs are sampled on the falling edge.
   task automatic mid();
      @(negedge clk);
   endtask

   task automatic clear_in();
      ifid_rs = '0; ifid_rt = '0; idex_rt = '0;
      ifid_uses_rt = 1'b0; idex_memread = 1'b0; br_taken = 1'b0;
      jump = 1'b0; md_start = 1'b0; cnt_clr = 1'b0;
   endtask

   initial begin
      clear_in();
      rst = 1'b0;
      br_taken = 1'b1;
      md_start = 1'b1;
      tick(); tick();
      mid();
      check("reset_ctrl_a", 32'(a_vec), 32'(V_RST));
      check("reset_ctrl_b", 32'(b_vec), 32'(V_RST));
      check("reset_stall", a_stall_cnt, 32'd0);
      check("reset_flush", a_flush_cnt, 32'd0);

      tick();
      clear_in();
      rst = 1'b1;
      mid();
      check("release_normal", 32'(a_vec), 32'(V_NORM));
      tick();
      check("release_stall", a_stall_cnt, 32'd0);

      // Load-use on rs: exactly one bubble
      idex_memread = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
      mid();
      check("lu_rs", 32'(a_vec), 32'(V_LU));
      tick();
      clear_in();
      check("lu_stall_cnt", a_stall_cnt, 32'd1);
      mid();
      check("lu_cleared", 32'(a_vec), 32'(V_NORM));
      tick();

      idex_memread = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0;
      mid();
      check("lu_r0", 32'(a_vec), 32'(V_NORM));
      tick();
      idex_rt = 5'd5; ifid_rs = 5'd3; ifid_rt = 5'd5; ifid_uses_rt = 1'b0;
      mid();
      check("lu_rt_unused", 32'(a_vec), 32'(V_NORM));
      tick();
      ifid_uses_rt = 1'b1;
      mid();
      check("lu_rt_used", 32'(a_vec), 32'(V_LU));
      tick();
      clear_in();
      check("lu_rt_stall_cnt", a_stall_cnt, 32'd2);

      // Redirect, then redirect masked by load-use
      br_taken = 1'b1;
      mid();
      check("redirect", 32'(a_vec), 32'(V_RD));
      tick();
      clear_in();
      check("redirect_flush_cnt", a_flush_cnt, 32'd1);
      br_taken = 1'b1; idex_memread = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
      mid();
      check("lu_over_rd", 32'(a_vec), 32'(V_LU));
      tick();
      clear_in();
      check("lu_over_rd_flush", a_flush_cnt, 32'd1);
      check("lu_over_rd_stall", a_stall_cnt, 32'd3);

      // Mul/div, MD_CYCLES=4: md_start held n..n+3
      md_start = 1'b1;
      mid();
      check("md_n", 32'(a_vec), 32'(V_FRZ0));
      tick();
      mid();
      check("md_n1", 32'(a_vec), 32'(V_FRZ1));
      tick();
      mid();
      check("md_n2", 32'(a_vec), 32'(V_FRZ1));
      tick();
      mid();
      check("md_release", 32'(a_vec), 32'(V_REL));
      tick();
      clear_in();
      mid();
      check("md_after", 32'(a_vec), 32'(V_NORM));
      check("md_stall_cnt", a_stall_cnt, 32'd6);
      tick();

      // Jump during MD_WAIT is held off until the release cycle
      md_start = 1'b1; jump = 1'b1;
      mid();
      check("jmp_frz_n", 32'(a_vec), 32'(V_FRZ0));
      tick();
      mid();
      check("jmp_frz_n1", 32'(a_vec), 32'(V_FRZ1));
      tick();
      mid();
      check("jmp_frz_n2", 32'(a_vec), 32'(V_FRZ1));
      tick();
      mid();
      check("jmp_release", 32'(a_vec), 32'(V_RELRD));
      tick();
      clear_in();
      check("jmp_flush_cnt", a_flush_cnt, 32'd2);
      check("jmp_stall_cnt", a_stall_cnt, 32'd9);

      // Reset in the middle of MD_WAIT aborts with no release cycle
      md_start = 1'b1;
      tick();
      clear_in();
      mid();
      check("abort_busy", 32'(a_vec), 32'(V_FRZ1));
      tick();
      rst = 1'b0;
      #1;
      check("abort_ctrl", 32'(a_vec), 32'(V_RST));
      check("abort_stall", a_stall_cnt, 32'd0);
      tick();
      rst = 1'b1;
      mid();
      check("abort_resume", 32'(a_vec), 32'(V_NORM));
      tick();

      // MD_CYCLES=2 build: single freeze cycle
      md_start = 1'b1;
      mid();
      check("md2_frz", 32'(b_vec), 32'(V_FRZ0));
      tick();
      mid();
      check("md2_release", 32'(b_vec), 32'(V_REL));
      tick();
      clear_in();
      mid();
      check("md2_after", 32'(b_vec), 32'(V_NORM));
      check("md2_stall_cnt", 32'(b_stall_cnt), 32'd1);
      tick();

      // CNT_W=4 saturation and clear-over-increment
      idex_memread = 1'b1; idex_rt = 5'd7; ifid_rs = 5'd7;
      for (int i = 0; i < 14; i++) tick();
      check("sat_reach", 32'(b_stall_cnt), 32'd15);
      for (int i = 0; i < 4; i++) tick();
      check("sat_hold", 32'(b_stall_cnt), 32'd15);
      cnt_clr = 1'b1;
      mid();
      check("clr_still_stalling", 32'(b_vec), 32'(V_LU));
      tick();
      check("clr_wins", 32'(b_stall_cnt), 32'd0);
      check("clr_wins_a", a_stall_cnt, 32'd0);
      clear_in();
      tick();
      check("clr_idle", 32'(b_stall_cnt), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
